conv_kxk_mac: RTL and testbench

Parametrised, pipelined K×K convolution multiply-accumulate engine with a programmable weight bank, bias, rounding quantisation, optional ReLU and output saturation. The block accepts one flattened K×K activation window per handshake and returns one quantised output pixel three cycles later. It supersedes the fixed 3×3, 8-bit combinational kernel and sits between the line-buffer/window generator and the output feature-map writer.

---
 rtl/conv_kxk_mac_if.sv | 25 ++
 rtl/conv_kxk_mac.sv | 139 +++++++++++++
 tb/tb_conv_kxk_mac.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_kxk_mac_if.sv
// Streaming window-in / pixel-out bundle for the KxK convolution MAC.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; the master drives in_* and out_ready.
interface conv_kxk_mac_if #(
  parameter int N  = 9,
  parameter int DW = 8,
  parameter int OW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_kxk_mac.sv
// KxK multiply-accumulate with weight bank, bias, rounding shift, ReLU and saturation.
// Latency: 3 cycles (multiply, accumulate, quantise), one window per cycle.
// Backpressure: single global stall, in_ready = !out_valid || out_ready; all stages hold.
module conv_kxk_mac #(
  parameter int K  = 3,
  parameter int DW = 8,
  parameter int WW = 8,
  parameter int OW = 8,
  parameter int SW = 5,
  localparam int N    = K * K,
  localparam int LOGN = $clog2(N),
  localparam int AW   = (LOGN > 0) ? LOGN : 1,
  localparam int PW   = DW + WW + 1,
  localparam int ACCW = PW + LOGN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   w_we,
  input  logic [AW-1:0]          w_addr,
  input  logic signed [WW-1:0]   w_data,
  input  logic signed [ACCW-1:0] bias,
  input  logic [SW-1:0]          quant_shift,
  input  logic                   relu_en,
  conv_kxk_mac_if.slave          io,
  output logic                   busy
);

  // Two spare bits: one for sum+bias, one so the rounding add never wraps.
  localparam int VW = ACCW + 2;
  localparam logic signed [VW-1:0] SAT_HI = VW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [VW-1:0] SAT_LO = -SAT_HI - VW'(1);

  logic                   advance;

  logic signed [WW-1:0]   w_q [N];
  logic signed [WW-1:0]   w_d [N];

  logic                   s1_vld_q, s1_vld_d;
  logic signed [PW-1:0]   s1_prod_q [N];
  logic signed [PW-1:0]   s1_prod_d [N];

  logic                   s2_vld_q, s2_vld_d;
  logic signed [ACCW-1:0] s2_sum_q, s2_sum_d;
  logic signed [ACCW-1:0] acc;

  logic signed [VW-1:0]   v_sum, v_rnd, v_shf;
  logic signed [OW-1:0]   q_val;

  logic                   out_vld_q, out_vld_d;
  logic signed [OW-1:0]   out_dat_q, out_dat_d;

  assign advance      = !out_vld_q || io.out_ready;
  assign io.in_ready  = advance;
  assign io.out_valid = out_vld_q;
  assign io.out_data  = out_dat_q;
  assign busy         = s1_vld_q | s1_vld_d & 1'b0 | s2_vld_q | out_vld_q;

  // Weight bank: out-of-range addresses match no entry and are dropped.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_d[i] = w_q[i];
      if (w_we && (w_addr == AW'(i))) w_d[i] = w_data;
    end
  end

  // S1: unsigned tap (zero-extended) times signed weight; sees pre-write weights.
  always_comb begin
    s1_vld_d = s1_vld_q;
    for (int i = 0; i < N; i++) s1_prod_d[i] = s1_prod_q[i];
    if (advance) begin
      s1_vld_d = io.in_valid;
      for (int i = 0; i < N; i++) begin
        s1_prod_d[i] = PW'($signed({1'b0, io.in_data[i*DW +: DW]})) * PW'(w_q[i]);
      end
    end
  end

  // S2: sign-extended sum of all products; ACCW leaves room for N terms.
  always_comb begin
    s2_vld_d = s2_vld_q;
    s2_sum_d = s2_sum_q;
    acc      = '0;
    for (int i = 0; i < N; i++) acc = acc + ACCW'(s1_prod_q[i]);
    if (advance) begin
      s2_vld_d = s1_vld_q;
      s2_sum_d = acc;
    end
  end

  // S3 datapath: bias, round half up, arithmetic shift, ReLU, saturate.
  always_comb begin
    v_sum = VW'(s2_sum_q) + VW'(bias);
    v_rnd = v_sum;
    if (quant_shift != '0) v_rnd = v_sum + (VW'(1) <<< (quant_shift - SW'(1)));
    // Shifting out every bit leaves only the sign of the unrounded value.
    if (32'(quant_shift) >= 32'(ACCW + 1)) v_shf = v_sum[VW-1] ? '1 : '0;
    else                                   v_shf = v_rnd >>> quant_shift;
    if (relu_en && v_shf[VW-1]) v_shf = '0;
    if (v_shf > SAT_HI)      q_val = SAT_HI[OW-1:0];
    else if (v_shf < SAT_LO) q_val = SAT_LO[OW-1:0];
    else                     q_val = v_shf[OW-1:0];
  end

  // S3 register: only real results overwrite out_data, bubbles leave it alone.
  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (advance) begin
      out_vld_d = s2_vld_q;
      if (s2_vld_q) out_dat_d = q_val;
    end
  end

  // State registers; reset discards everything in flight and clears weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        w_q[i]       <= '0;
        s1_prod_q[i] <= '0;
      end
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_sum_q  <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        w_q[i]       <= w_d[i];
        s1_prod_q[i] <= s1_prod_d[i];
      end
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      s2_sum_q  <= s2_sum_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

endmodule

// File: tb/tb_conv_kxk_mac.sv
// Directed bench for conv_kxk_mac with K=3, DW=WW=OW=8.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// Expected values are hand-computed from the arithmetic of each scenario.
module tb_conv_kxk_mac;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              w_we;
  logic [3:0]        w_addr;
  logic signed [7:0] w_data;
  logic signed [20:0] bias;
  logic [4:0]        quant_shift;
  logic              relu_en;
  logic              busy;

  int checks = 0;
  int errors = 0;

  int   sent, got, cyc, stalls;
  logic stall_prev;
  logic [7:0] prev_dat;

  conv_kxk_mac_if #(.N(9), .DW(8), .OW(8)) io ();

  conv_kxk_mac dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .w_we        (w_we),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .bias        (bias),
    .quant_shift (quant_shift),
    .relu_en     (relu_en),
    .io          (io.slave),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int a, input int v);
    w_we   = 1'b1;
    w_addr = 4'(a);
    w_data = 8'(v);
    tick;
    w_we   = 1'b0;
  endtask

  task automatic set_all_w(input int v);
    for (int i = 0; i < 9; i++) write_w(i, v);
  endtask

  function automatic logic [71:0] fill(input int t);
    logic [7:0] b;
    b = 8'(t);
    return {9{b}};
  endfunction

  function automatic logic [71:0] tap0(input int t);
    return {64'd0, 8'(t)};
  endfunction

  // One window in, wait (bounded) for its result, compare, then consume it.
  task automatic run_one(input string tag, input logic [71:0] win, input int exp);
    int n;
    io.in_valid = 1'b1;
    io.in_data  = win;
    tick;
    io.in_valid = 1'b0;
    n = 0;
    while (io.out_valid !== 1'b1 && n < 8) begin
      tick;
      n++;
    end
    check(tag, (io.out_valid === 1'b1) ? 32'($signed(io.out_data)) : 'x, exp);
    tick;
  endtask

  initial begin
    rst_n        = 1'b0;
    w_we         = 1'b0;
    w_addr       = '0;
    w_data       = '0;
    bias         = '0;
    quant_shift  = '0;
    relu_en      = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;

    // Reset state
    tick;
    tick;
    check("rst_out_valid", 32'(io.out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_data", 32'(io.out_data), 0);
    rst_n = 1'b1;
    tick;
    check("rst_in_ready", 32'(io.in_ready), 1);
    io.out_ready = 1'b1;

    // Basic MAC with latency: 9 * 1 * 10 = 90, valid after the third edge
    set_all_w(1);
    io.in_valid = 1'b1;
    io.in_data  = fill(10);
    tick;
    io.in_valid = 1'b0;
    check("mac_lat1_valid", 32'(io.out_valid), 0);
    check("mac_lat1_busy", 32'(busy), 1);
    tick;
    check("mac_lat2_valid", 32'(io.out_valid), 0);
    tick;
    check("mac_valid", 32'(io.out_valid), 1);
    check("mac_data", 32'($signed(io.out_data)), 90);
    tick;
    check("mac_drain_valid", 32'(io.out_valid), 0);
    check("mac_drain_busy", 32'(busy), 0);

    // Saturation and ReLU: 9*(-128*255) = -293760 -> -18360 -> -128
    set_all_w(-128);
    quant_shift = 5'd4;
    run_one("sat_neg", fill(255), -128);
    relu_en = 1'b1;
    run_one("relu_neg", fill(255), 0);
    relu_en = 1'b0;
    set_all_w(127);
    quant_shift = 5'd0;
    run_one("sat_pos", fill(255), 127);

    // Rounding with a single non-zero tap
    set_all_w(0);
    write_w(0, 1);
    quant_shift = 5'd1;
    run_one("rnd_5_s1", tap0(5), 3);
    quant_shift = 5'd2;
    run_one("rnd_7_s2", tap0(7), 2);
    write_w(0, -1);
    run_one("rnd_m6_s2", tap0(6), -1);
    quant_shift = 5'd25;
    run_one("bigshift_neg", tap0(6), 0 - 1);
    write_w(0, 1);
    run_one("bigshift_pos", tap0(6), 0);
    quant_shift = 5'd0;
    write_w(15, 50);
    run_one("oob_addr", fill(1), 1);
    bias = -21'sd3;
    run_one("bias_only", tap0(0), -3);
    bias = '0;

    // Backpressure: 6 windows back to back, out_ready low for cycles 4..7
    set_all_w(1);
    sent = 0; got = 0; cyc = 0; stalls = 0;
    stall_prev = 1'b0;
    prev_dat   = '0;
    while (got < 6 && cyc < 40) begin
      io.out_ready = !(cyc >= 4 && cyc < 8);
      io.in_valid  = (sent < 6);
      io.in_data   = fill(sent + 1);
      #1;
      check("bp_in_ready", 32'(io.in_ready), 32'(!(io.out_valid && !io.out_ready)));
      if (io.out_valid === 1'b1) begin
        if (stall_prev) check("bp_hold", 32'(io.out_data), 32'(prev_dat));
        if (io.out_ready) begin
          check("bp_data", 32'(io.out_data), 9 * (got + 1));
          got++;
        end
      end
      stall_prev = io.out_valid && !io.out_ready;
      if (stall_prev) stalls++;
      prev_dat = io.out_data;
      if (io.in_valid && io.in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    check("bp_count", got, 6);
    check("bp_sent", sent, 6);
    check("bp_stall_cycles", stalls, 4);

    // Weight write in the acceptance cycle of A: A sees old weight, B new
    io.in_valid = 1'b1;
    io.in_data  = fill(1);
    w_we   = 1'b1;
    w_addr = 4'd4;
    w_data = 8'sd2;
    tick;
    w_we = 1'b0;
    tick;
    io.in_valid = 1'b0;
    got = 0; cyc = 0;
    while (got < 2 && cyc < 10) begin
      if (io.out_valid === 1'b1) begin
        check(got == 0 ? "wu_a" : "wu_b", 32'($signed(io.out_data)), got == 0 ? 9 : 10);
        got++;
      end
      tick;
      cyc++;
    end
    check("wu_count", got, 2);

    // Reset with two windows in flight
    io.in_valid = 1'b1;
    io.in_data  = fill(3);
    tick;
    tick;
    io.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rm_out_valid", 32'(io.out_valid), 0);
    check("rm_busy", 32'(busy), 0);
    check("rm_out_data", 32'(io.out_data), 0);
    tick;
    rst_n = 1'b1;
    tick;
    check("rm_in_ready", 32'(io.in_ready), 1);
    run_one("rm_zero_weights", fill(10), 0);
    bias = 21'sd5;
    run_one("rm_bias_only", fill(10), 5);
    bias = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
